regfile_dump_ctrl: RTL and testbench

Read-side sequencer for the 32x32 RegisterFile (two combinational read ports a1/a2 -> do1/do2). On a start pulse it sweeps all registers in even/odd pairs, snapshots each pair, and streams the words out one per beat over a valid/ready interface. It serves as a debug/state-dump unit alongside the datapath and takes over the RF read ports while busy.

---
 rtl/regfile_dump_ctrl_pkg.sv | 18 +
 rtl/regfile_dump_ctrl.sv | 145 ++++++++++++++
 tb/tb_regfile_dump_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_ctrl_pkg.sv
// Shared constants for the register-file dump sequencer.
// Defaults match the 32x32 RegisterFile it reads from.
// State encoding is shared so debug tooling can decode the FSM.
package regfile_dump_ctrl_pkg;

  localparam int RF_NREG = 32;
  localparam int RF_AW   = 5;
  localparam int RF_DW   = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    EMIT_LO = 3'd2,
    EMIT_HI = 3'd3,
    FIN     = 3'd4
  } dump_state_t;

endpackage

// File: rtl/regfile_dump_ctrl.sv
// Sweeps the register file in even/odd pairs and streams each word out.
// Latency: start -> READ next cycle -> first word valid two cycles after start; 3 cycles/pair at full rate.
// Backpressure: valid/ready; output word held stable until accepted, abort drops it.
module regfile_dump_ctrl
  import regfile_dump_ctrl_pkg::*;
#(
  parameter int NREG = RF_NREG,
  parameter int AW   = RF_AW,
  parameter int DW   = RF_DW
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  output logic [AW-1:0] rf_a1,
  output logic [AW-1:0] rf_a2,
  input  logic [DW-1:0] rf_do1,
  input  logic [DW-1:0] rf_do2,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic          done
);

  // The system top muxes the RF read ports between the datapath and this
  // block using busy; rf_a1/rf_a2 therefore only need to be valid while busy.

  dump_state_t   state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] a1_d, a2_d;
  logic [DW-1:0] lo_buf, hi_buf, lo_d, hi_d;
  logic          valid_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] data_d;
  logic          busy_d, done_d;
  logic          handshake;
  logic          last_pair;

  assign handshake = out_valid & out_ready;
  // ptr only holds even values, so ptr+1 never wraps for a legal NREG.
  assign last_pair = ((ptr_q + AW'(1)) == AW'(NREG - 1));

  // Next-state and next-output logic; abort overrides every transition.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    a1_d    = rf_a1;
    a2_d    = rf_a2;
    lo_d    = lo_buf;
    hi_d    = hi_buf;
    valid_d = out_valid;
    addr_d  = out_addr;
    data_d  = out_data;

    case (state_q)
      IDLE: begin
        if (start) begin
          ptr_d   = '0;
          a1_d    = '0;
          a2_d    = AW'(1);
          state_d = READ;
        end
      end
      READ: begin
        // Snapshot the pair; later RF writes cannot disturb what is emitted.
        lo_d    = rf_do1;
        hi_d    = rf_do2;
        valid_d = 1'b1;
        addr_d  = ptr_q;
        data_d  = rf_do1;
        state_d = EMIT_LO;
      end
      EMIT_LO: begin
        if (handshake) begin
          addr_d  = ptr_q + AW'(1);
          data_d  = hi_buf;
          state_d = EMIT_HI;
        end
      end
      EMIT_HI: begin
        if (handshake) begin
          valid_d = 1'b0;
          if (last_pair) begin
            state_d = FIN;
          end else begin
            ptr_d   = ptr_q + AW'(2);
            a1_d    = ptr_q + AW'(2);
            a2_d    = ptr_q + AW'(3);
            state_d = READ;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase

    if (abort) begin
      state_d = IDLE;
      ptr_d   = ptr_q;
      a1_d    = rf_a1;
      a2_d    = rf_a2;
      valid_d = 1'b0;
    end

    busy_d = (state_d == READ) || (state_d == EMIT_LO) || (state_d == EMIT_HI);
    done_d = (state_d == FIN);
  end

  // State, pointer, snapshot buffers and registered outputs.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      rf_a1     <= '0;
      rf_a2     <= '0;
      lo_buf    <= '0;
      hi_buf    <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rf_a1     <= a1_d;
      rf_a2     <= a2_d;
      lo_buf    <= lo_d;
      hi_buf    <= hi_d;
      out_valid <= valid_d;
      out_addr  <= addr_d;
      out_data  <= data_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Directed bench for regfile_dump_ctrl with a behavioural 32x32 register file.
// Cycle 0 is the cycle in which start is driven; outputs are sampled on the falling edge.
// Each scenario task makes its own comparisons against hand-computed values.
module tb_regfile_dump_ctrl;

  logic        CLK = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [4:0]  rf_a1, rf_a2;
  logic [31:0] rf_do1, rf_do2;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic        busy;
  logic        done;

  logic [31:0] rf_mem [0:31];

  int n_cmp = 0;
  int n_err = 0;

  // Results gathered by run_dump
  int          q_addr [$];
  logic [31:0] q_data [$];
  int first_valid, done_cyc, done_cnt, hold_err, abort_at;
  int busy_c1, post_valid, post_busy, end_busy, end_valid;
  int timed_out;

  regfile_dump_ctrl #(.NREG(32), .AW(5), .DW(32)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .rf_a1     (rf_a1),
    .rf_a2     (rf_a2),
    .rf_do1    (rf_do1),
    .rf_do2    (rf_do2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  assign rf_do1 = rf_mem[rf_a1];
  assign rf_do2 = rf_mem[rf_a2];

  always #5 CLK = ~CLK;

  task automatic preload();
    for (int k = 0; k < 32; k++) rf_mem[k] = 32'(k * 10);
  endtask

  // Stimulus driver: starts a dump at cycle 0 and records accepted beats.
  // ready_mode 0 = always ready, 1 = ready on even cycles only.
  task automatic run_dump(input int ready_mode, input int restart_cyc,
                          input int abort_addr, input int stall_addr);
    int  stall_left;
    bit  pend;
    bit  finished;
    logic [4:0]  p_addr;
    logic [31:0] p_data;
    logic rdy;
    q_addr.delete();
    q_data.delete();
    first_valid = -1; done_cyc = -1; done_cnt = 0; hold_err = 0; abort_at = -1;
    busy_c1 = -1; post_valid = -1; post_busy = -1; end_busy = -1; end_valid = -1;
    timed_out = 0;
    stall_left = 3;
    pend = 1'b0;
    finished = 1'b0;
    p_addr = '0;
    p_data = '0;
    for (int c = 0; c <= 400; c++) begin
      @(negedge CLK);
      if (pend && (out_valid !== 1'b1 || out_addr !== p_addr || out_data !== p_data))
        hold_err++;
      if (out_valid === 1'b1 && first_valid < 0) first_valid = c;
      if (done === 1'b1) begin done_cnt++; done_cyc = c; end
      if (c == 1) busy_c1 = int'(busy);
      if (abort_at >= 0 && c == abort_at + 1) begin
        post_valid = int'(out_valid);
        post_busy  = int'(busy);
      end
      start = (c == 0) || (c == restart_cyc);
      abort = 1'b0;
      rdy = (ready_mode == 1) ? ((c % 2) == 0) : 1'b1;
      if (stall_addr >= 0 && out_valid === 1'b1 && int'(out_addr) == stall_addr && stall_left > 0) begin
        rdy = 1'b0;
        if (stall_left == 3) rf_mem[stall_addr + 1] = 32'hDEAD;
        stall_left--;
      end
      if (abort_addr >= 0 && out_valid === 1'b1 && int'(out_addr) == abort_addr && abort_at < 0) begin
        abort = 1'b1;
        abort_at = c;
      end
      out_ready = rdy;
      if (out_valid === 1'b1 && out_ready && !abort) begin
        q_addr.push_back(int'(out_addr));
        q_data.push_back(out_data);
      end
      pend = (out_valid === 1'b1) && !out_ready && !abort;
      p_addr = out_addr;
      p_data = out_data;
      if ((done_cyc >= 0 && c >= done_cyc + 2) || (abort_at >= 0 && c >= abort_at + 3)) begin
        end_busy  = int'(busy);
        end_valid = int'(out_valid);
        finished  = 1'b1;
        break;
      end
    end
    start = 1'b0;
    abort = 1'b0;
    if (!finished) timed_out = 1;
  endtask

  task automatic test_reset();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (out_addr !== 5'd0) begin n_err++; $display("FAIL reset_addr: got %0d want 0", out_addr); end
    n_cmp++; if (out_data !== 32'd0) begin n_err++; $display("FAIL reset_data: got %0h want 0", out_data); end
    n_cmp++; if (rf_a1 !== 5'd0) begin n_err++; $display("FAIL reset_a1: got %0d want 0", rf_a1); end
    n_cmp++; if (rf_a2 !== 5'd0) begin n_err++; $display("FAIL reset_a2: got %0d want 0", rf_a2); end
  endtask

  task automatic test_full_dump();
    preload();
    run_dump(0, -1, -1, -1);
    n_cmp++; if (timed_out !== 0) begin n_err++; $display("FAIL full_timeout: got %0d want 0", timed_out); end
    n_cmp++; if (q_addr.size() !== 32) begin n_err++; $display("FAIL full_count: got %0d want 32", q_addr.size()); end
    for (int i = 0; i < q_addr.size() && i < 32; i++) begin
      n_cmp++; if (q_addr[i] !== i) begin n_err++; $display("FAIL full_addr[%0d]: got %0d want %0d", i, q_addr[i], i); end
      n_cmp++; if (q_data[i] !== 32'(i * 10)) begin n_err++; $display("FAIL full_data[%0d]: got %0d want %0d", i, q_data[i], i * 10); end
    end
    n_cmp++; if (first_valid !== 2) begin n_err++; $display("FAIL full_first_valid: got %0d want 2", first_valid); end
    n_cmp++; if (busy_c1 !== 1) begin n_err++; $display("FAIL full_busy_c1: got %0d want 1", busy_c1); end
    n_cmp++; if (done_cyc !== 49) begin n_err++; $display("FAIL full_done_cyc: got %0d want 49", done_cyc); end
    n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL full_done_cnt: got %0d want 1", done_cnt); end
    n_cmp++; if (end_busy !== 0) begin n_err++; $display("FAIL full_busy_end: got %0d want 0", end_busy); end
  endtask

  task automatic test_backpressure();
    preload();
    run_dump(1, -1, -1, -1);
    n_cmp++; if (timed_out !== 0) begin n_err++; $display("FAIL bp_timeout: got %0d want 0", timed_out); end
    n_cmp++; if (q_addr.size() !== 32) begin n_err++; $display("FAIL bp_count: got %0d want 32", q_addr.size()); end
    for (int i = 0; i < q_addr.size() && i < 32; i++) begin
      n_cmp++; if (q_addr[i] !== i) begin n_err++; $display("FAIL bp_addr[%0d]: got %0d want %0d", i, q_addr[i], i); end
      n_cmp++; if (q_data[i] !== 32'(i * 10)) begin n_err++; $display("FAIL bp_data[%0d]: got %0d want %0d", i, q_data[i], i * 10); end
    end
    n_cmp++; if (hold_err !== 0) begin n_err++; $display("FAIL bp_hold: got %0d unstable cycles want 0", hold_err); end
    n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL bp_done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_start_while_busy();
    preload();
    run_dump(0, 10, -1, -1);
    n_cmp++; if (q_addr.size() !== 32) begin n_err++; $display("FAIL restart_count: got %0d want 32", q_addr.size()); end
    for (int i = 0; i < q_addr.size() && i < 32; i++) begin
      n_cmp++; if (q_addr[i] !== i) begin n_err++; $display("FAIL restart_addr[%0d]: got %0d want %0d", i, q_addr[i], i); end
    end
    n_cmp++; if (done_cyc !== 49) begin n_err++; $display("FAIL restart_done_cyc: got %0d want 49", done_cyc); end
    n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL restart_done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_abort();
    preload();
    run_dump(0, -1, 7, -1);
    n_cmp++; if (abort_at < 0) begin n_err++; $display("FAIL abort_seen: addr 7 never presented"); end
    n_cmp++; if (q_addr.size() !== 7) begin n_err++; $display("FAIL abort_count: got %0d want 7", q_addr.size()); end
    n_cmp++; if (post_valid !== 0) begin n_err++; $display("FAIL abort_valid: got %0d want 0", post_valid); end
    n_cmp++; if (post_busy !== 0) begin n_err++; $display("FAIL abort_busy: got %0d want 0", post_busy); end
    n_cmp++; if (done_cnt !== 0) begin n_err++; $display("FAIL abort_done: got %0d pulses want 0", done_cnt); end
    n_cmp++; if (end_valid !== 0) begin n_err++; $display("FAIL abort_resume: got valid %0d want 0", end_valid); end
    // abort and start together in IDLE: abort wins
    @(negedge CLK); start = 1'b1; abort = 1'b1;
    @(negedge CLK); start = 1'b0; abort = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_start_busy: got %b want 0", busy); end
    @(negedge CLK);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL abort_start_valid: got %b want 0", out_valid); end
    // a fresh dump starts at register 0
    run_dump(0, -1, -1, -1);
    n_cmp++; if (q_addr.size() !== 32) begin n_err++; $display("FAIL abort_redump_count: got %0d want 32", q_addr.size()); end
    if (q_addr.size() > 9) begin
      n_cmp++; if (q_addr[0] !== 0) begin n_err++; $display("FAIL abort_redump_addr0: got %0d want 0", q_addr[0]); end
      n_cmp++; if (q_data[7] !== 32'd70) begin n_err++; $display("FAIL abort_redump_data7: got %0d want 70", q_data[7]); end
    end
  endtask

  task automatic test_snapshot();
    preload();
    run_dump(0, -1, -1, 4);
    n_cmp++; if (q_addr.size() !== 32) begin n_err++; $display("FAIL snap_count: got %0d want 32", q_addr.size()); end
    if (q_addr.size() > 5) begin
      n_cmp++; if (q_data[4] !== 32'd40) begin n_err++; $display("FAIL snap_data4: got %0d want 40", q_data[4]); end
      n_cmp++; if (q_data[5] !== 32'd50) begin n_err++; $display("FAIL snap_data5: got %0h want 32", q_data[5]); end
    end
    n_cmp++; if (hold_err !== 0) begin n_err++; $display("FAIL snap_hold: got %0d unstable cycles want 0", hold_err); end
    run_dump(0, -1, -1, -1);
    if (q_addr.size() > 5) begin
      n_cmp++; if (q_data[5] !== 32'hDEAD) begin n_err++; $display("FAIL snap_redump5: got %0h want dead", q_data[5]); end
    end else begin
      n_cmp++; n_err++; $display("FAIL snap_redump_count: got %0d want 32", q_addr.size());
    end
  endtask

  task automatic test_reset_mid_dump();
    bit saw;
    preload();
    @(negedge CLK); start = 1'b1; out_ready = 1'b1;   // cycle 0
    @(negedge CLK); start = 1'b0;                     // cycle 1
    repeat (5) @(negedge CLK);                        // cycle 6: EMIT_HI addr 3
    n_cmp++; if (out_valid !== 1'b1 || out_addr !== 5'd3) begin
      n_err++; $display("FAIL mid_pre: got valid %b addr %0d want 1/3", out_valid, out_addr);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL mid_done: got %b want 0", done); end
    n_cmp++; if (out_addr !== 5'd0) begin n_err++; $display("FAIL mid_addr: got %0d want 0", out_addr); end
    n_cmp++; if (out_data !== 32'd0) begin n_err++; $display("FAIL mid_data: got %0h want 0", out_data); end
    @(negedge CLK); reset = 1'b0;
    saw = 1'b0;
    repeat (8) begin
      @(negedge CLK);
      if (out_valid !== 1'b0 || busy !== 1'b0) saw = 1'b1;
    end
    n_cmp++; if (saw !== 1'b0) begin n_err++; $display("FAIL mid_quiet: got activity %b want 0", saw); end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    out_ready = 1'b0;
    preload();
    @(negedge CLK);
    test_reset();
    reset = 1'b0;
    @(negedge CLK);
    test_full_dump();
    test_backpressure();
    test_start_while_busy();
    test_abort();
    test_snapshot();
    test_reset_mid_dump();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
